// File: rtl/riscv_configs.sv
// rtl/riscv_configs.sv - shared RISC-V datapath constants
// Purpose: datapath width, WB source encodings, load funct3 codes and WB payload width.
// Ports: none (package).
package riscv_configs;

   localparam int RV_XLEN = 32;

   // Write-back source select (src_rd)
   localparam logic [1:0] SRC_RD_ALU = 2'd0;
   localparam logic [1:0] SRC_RD_MEM = 2'd1;
   localparam logic [1:0] SRC_RD_PC4 = 2'd2;
   localparam logic [1:0] SRC_RD_IMM = 2'd3;

   // Load funct3 codes
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // WB payload = {reg_wr_en, rd[4:0], wb_data[xlen-1:0]}
   function automatic int wb_payload_w(input int xlen);
      return 1 + 5 + xlen;
   endfunction

endpackage

// File: rtl/riscv_load_ext.sv
// rtl/riscv_load_ext.sv - load data align and sign/zero extension
// Purpose: picks the addressed byte/halfword out of the raw aligned load word and extends it.
// Ports:
//   word   [XLEN-1:0] in  raw aligned-word load data
//   addr   [1:0]      in  byte offset within the word (alu_out[1:0])
//   funct3 [2:0]      in  load size/sign code
//   data   [XLEN-1:0] out aligned and extended load value
module riscv_load_ext
   import riscv_configs::*;
#(
   parameter int XLEN = RV_XLEN
) (
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      addr,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   always_comb begin
      sel_byte = word[{addr, 3'b000} +: 8];
      // Halfword uses addr[1] only; a misaligned addr[0] is deliberately ignored here.
      sel_half = addr[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_LB:   data = {{(XLEN-8){sel_byte[7]}}, sel_byte};
         F3_LBU:  data = {{(XLEN-8){1'b0}}, sel_byte};
         F3_LH:   data = {{(XLEN-16){sel_half[15]}}, sel_half};
         F3_LHU:  data = {{(XLEN-16){1'b0}}, sel_half};
         F3_LW:   data = word;
         default: data = word;
      endcase
   end

endmodule

// File: rtl/riscv_memwb_stage.sv
// rtl/riscv_memwb_stage.sv - elastic MEM->WB stage with one-entry skid buffer
// Purpose: extends load data, selects the write-back value and registers it behind a
//          valid/ready handshake; WB back-pressure never drops or duplicates a beat.
// Ports:
//   i_clk, i_rstn                      clock, synchronous active-low reset
//   i_MEM_valid / o_MEM_ready          upstream handshake
//   i_MEM_reg_wr_en, i_MEM_rd          destination write enable / register
//   i_MEM_src_rd, i_MEM_funct3         WB source select, load size/sign
//   i_MEM_alu_out, i_MEM_mem_rd_data   ALU result (address), raw load word
//   i_MEM_pc4, i_MEM_imm               PC+4, immediate
//   i_flush                            discard all held beats
//   o_WB_valid / i_WB_ready            downstream handshake
//   o_WB_reg_wr_en, o_WB_rd, o_WB_rd_data  write-back payload
module riscv_memwb_stage
   import riscv_configs::*;
#(
   parameter int XLEN = RV_XLEN
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_MEM_valid,
   output logic            o_MEM_ready,
   input  logic            i_MEM_reg_wr_en,
   input  logic [4:0]      i_MEM_rd,
   input  logic [1:0]      i_MEM_src_rd,
   input  logic [2:0]      i_MEM_funct3,
   input  logic [XLEN-1:0] i_MEM_alu_out,
   input  logic [XLEN-1:0] i_MEM_mem_rd_data,
   input  logic [XLEN-1:0] i_MEM_pc4,
   input  logic [XLEN-1:0] i_MEM_imm,
   input  logic            i_flush,
   output logic            o_WB_valid,
   input  logic            i_WB_ready,
   output logic            o_WB_reg_wr_en,
   output logic [4:0]      o_WB_rd,
   output logic [XLEN-1:0] o_WB_rd_data
);

   localparam int PW = wb_payload_w(XLEN);

   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] wb_data;
   logic [PW-1:0]   in_payload;
   logic [PW-1:0]   main_q;
   logic [PW-1:0]   skid_q;
   logic            main_valid;
   logic            skid_valid;
   logic            accept;
   logic            emit;

   riscv_load_ext #(.XLEN(XLEN)) u_load_ext (
      .word   (i_MEM_mem_rd_data),
      .addr   (i_MEM_alu_out[1:0]),
      .funct3 (i_MEM_funct3),
      .data   (load_data)
   );

   always_comb begin
      case (i_MEM_src_rd)
         SRC_RD_ALU: wb_data = i_MEM_alu_out;
         SRC_RD_MEM: wb_data = load_data;
         SRC_RD_PC4: wb_data = i_MEM_pc4;
         SRC_RD_IMM: wb_data = i_MEM_imm;
         default:    wb_data = i_MEM_alu_out;
      endcase
   end

   // x0 is never written, so the enable is squashed before storage.
   assign in_payload = {i_MEM_reg_wr_en & (i_MEM_rd != 5'd0), i_MEM_rd, wb_data};

   // Ready depends only on registered skid state (plus reset), never on i_WB_ready.
   assign o_MEM_ready = i_rstn & ~skid_valid;
   assign accept      = i_MEM_valid & o_MEM_ready;
   assign emit        = main_valid & i_WB_ready;

   // skid_valid implies main_valid, so main is always the oldest beat.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (i_flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (!main_valid) begin
         if (accept) begin
            main_q     <= in_payload;
            main_valid <= 1'b1;
         end
      end else if (skid_valid) begin
         // Upstream is stalled here, so only an emit can change state.
         if (emit) begin
            main_q     <= skid_q;
            skid_valid <= 1'b0;
         end
      end else begin
         if (accept && emit) begin
            main_q <= in_payload;
         end else if (accept) begin
            skid_q     <= in_payload;
            skid_valid <= 1'b1;
         end else if (emit) begin
            main_valid <= 1'b0;
         end
      end
   end

   assign o_WB_valid     = main_valid;
   assign o_WB_reg_wr_en = main_valid & main_q[PW-1];
   assign o_WB_rd        = main_q[PW-2 -: 5];
   assign o_WB_rd_data   = main_q[XLEN-1:0];

endmodule

// File: tb/tb_riscv_memwb_stage.sv
// tb/tb_riscv_memwb_stage.sv - scoreboard bench for riscv_memwb_stage
module tb_riscv_memwb_stage;

   typedef struct packed {
      logic        wr;
      logic [4:0]  rd;
      logic [1:0]  src;
      logic [2:0]  f3;
      logic [31:0] alu;
      logic [31:0] mrd;
      logic [31:0] pc4;
      logic [31:0] imm;
   } beat_t;

   logic        i_clk = 1'b0;
   logic        i_rstn = 1'b0;
   logic        i_MEM_valid = 1'b0;
   logic        o_MEM_ready;
   logic        i_MEM_reg_wr_en = 1'b0;
   logic [4:0]  i_MEM_rd = '0;
   logic [1:0]  i_MEM_src_rd = '0;
   logic [2:0]  i_MEM_funct3 = '0;
   logic [31:0] i_MEM_alu_out = '0;
   logic [31:0] i_MEM_mem_rd_data = '0;
   logic [31:0] i_MEM_pc4 = '0;
   logic [31:0] i_MEM_imm = '0;
   logic        i_flush = 1'b0;
   logic        o_WB_valid;
   logic        i_WB_ready = 1'b0;
   logic        o_WB_reg_wr_en;
   logic [4:0]  o_WB_rd;
   logic [31:0] o_WB_rd_data;

   int n_checks = 0;
   int n_pass = 0;
   logic [37:0] sb[$];

   riscv_memwb_stage dut (
      .i_clk             (i_clk),
      .i_rstn            (i_rstn),
      .i_MEM_valid       (i_MEM_valid),
      .o_MEM_ready       (o_MEM_ready),
      .i_MEM_reg_wr_en   (i_MEM_reg_wr_en),
      .i_MEM_rd          (i_MEM_rd),
      .i_MEM_src_rd      (i_MEM_src_rd),
      .i_MEM_funct3      (i_MEM_funct3),
      .i_MEM_alu_out     (i_MEM_alu_out),
      .i_MEM_mem_rd_data (i_MEM_mem_rd_data),
      .i_MEM_pc4         (i_MEM_pc4),
      .i_MEM_imm         (i_MEM_imm),
      .i_flush           (i_flush),
      .o_WB_valid        (o_WB_valid),
      .i_WB_ready        (i_WB_ready),
      .o_WB_reg_wr_en    (o_WB_reg_wr_en),
      .o_WB_rd           (o_WB_rd),
      .o_WB_rd_data      (o_WB_rd_data)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
   endtask

   // Reference: expected {reg_wr_en, rd, data} from the ISA load/select rules.
   function automatic logic [37:0] model(input beat_t b);
      longint unsigned byte_v, half_v, data;
      byte_v = (longint'(b.mrd) >> (8 * b.alu[1:0])) & 64'hFF;
      half_v = (longint'(b.mrd) >> (16 * b.alu[1])) & 64'hFFFF;
      case (b.src)
         2'd0: data = b.alu;
         2'd2: data = b.pc4;
         2'd3: data = b.imm;
         default: begin
            case (b.f3)
               3'b000:  data = (byte_v >= 128) ? byte_v + 64'hFFFF_FF00 : byte_v;
               3'b100:  data = byte_v;
               3'b001:  data = (half_v >= 32768) ? half_v + 64'hFFFF_0000 : half_v;
               3'b101:  data = half_v;
               default: data = b.mrd;
            endcase
         end
      endcase
      return {b.wr && (b.rd != 0), b.rd, data[31:0]};
   endfunction

   function automatic beat_t rand_beat();
      beat_t b;
      b.wr  = 1'($urandom);
      b.rd  = 5'($urandom);
      b.src = 2'($urandom);
      b.f3  = 3'($urandom);
      b.alu = $urandom;
      b.mrd = $urandom;
      b.pc4 = $urandom;
      b.imm = $urandom;
      return b;
   endfunction

   function automatic beat_t mk(input logic wr, input logic [4:0] rd, input logic [1:0] src,
                                input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] mrd,
                                input logic [31:0] pc4, input logic [31:0] imm);
      beat_t b;
      b.wr = wr; b.rd = rd; b.src = src; b.f3 = f3;
      b.alu = alu; b.mrd = mrd; b.pc4 = pc4; b.imm = imm;
      return b;
   endfunction

   // One clock: apply inputs just after the edge, then record what the next edge accepts.
   task automatic step(input beat_t b, input logic v, input logic wbr, input logic fl, input logic rst);
      @(posedge i_clk);
      #1;
      i_rstn = rst; i_flush = fl; i_WB_ready = wbr; i_MEM_valid = v;
      i_MEM_reg_wr_en = b.wr; i_MEM_rd = b.rd; i_MEM_src_rd = b.src; i_MEM_funct3 = b.f3;
      i_MEM_alu_out = b.alu; i_MEM_mem_rd_data = b.mrd; i_MEM_pc4 = b.pc4; i_MEM_imm = b.imm;
      #1;
      if (!rst || fl) sb.delete();
      else if (v && o_MEM_ready) sb.push_back(model(b));
   endtask

   // Monitor: pops the scoreboard on every emit, and checks payload holds under stall.
   logic        prev_stall = 1'b0;
   logic [38:0] prev_pl = '0;
   always @(negedge i_clk) begin
      if (!i_rstn || i_flush) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            chk("hold_stable", {25'd0, o_WB_valid, o_WB_reg_wr_en, o_WB_rd, o_WB_rd_data}, {25'd0, prev_pl});
         if (o_WB_valid && i_WB_ready) begin
            if (sb.size() == 0) chk("unexpected_beat", 64'd1, 64'd0);
            else chk("wb_beat", {26'd0, o_WB_reg_wr_en, o_WB_rd, o_WB_rd_data}, {26'd0, sb.pop_front()});
         end
         prev_stall = o_WB_valid && !i_WB_ready;
         prev_pl = {o_WB_valid, o_WB_reg_wr_en, o_WB_rd, o_WB_rd_data};
      end
   end

   beat_t idle_b;
   beat_t bx;

   initial begin
      idle_b = '0;
      // Reset
      step(idle_b, 0, 0, 0, 0);
      step(idle_b, 0, 0, 0, 0);
      chk("ready_in_reset", 64'(o_MEM_ready), 64'd0);
      step(idle_b, 0, 1, 0, 1);
      chk("reset_outputs", {27'd0, o_WB_valid, o_WB_reg_wr_en, o_WB_rd, o_WB_rd_data}, 64'd0);
      chk("ready_after_reset", 64'(o_MEM_ready), 64'd1);

      // LB with one-cycle latency
      step(mk(1, 5, 1, 3'b000, 32'h1003, 32'h80FF_1234, 0, 0), 1, 1, 0, 1);
      step(idle_b, 0, 1, 0, 1);
      chk("lb_latency_valid", 64'(o_WB_valid), 64'd1);
      chk("lb_rd_data", 64'(o_WB_rd_data), 64'hFFFF_FF80);
      step(idle_b, 0, 1, 0, 1);

      // LHU / LH, x0 squash, pc4 / imm select
      step(mk(1, 6, 1, 3'b101, 32'h2002, 32'hABCD_0001, 0, 0), 1, 1, 0, 1);
      step(mk(1, 7, 1, 3'b001, 32'h2002, 32'hABCD_0001, 0, 0), 1, 1, 0, 1);
      step(mk(1, 0, 0, 3'b000, 32'h1234, 0, 0, 0), 1, 1, 0, 1);
      step(idle_b, 0, 1, 0, 1);
      chk("x0_no_write", {31'd0, o_WB_reg_wr_en, o_WB_rd_data}, {32'd0, 32'h1234});
      step(mk(1, 8, 2, 3'b010, 32'h1, 32'h2, 32'h0000_0104, 32'hABCD_E000), 1, 1, 0, 1);
      step(mk(1, 9, 3, 3'b010, 32'h1, 32'h2, 32'h0000_0104, 32'hABCD_E000), 1, 1, 0, 1);
      step(idle_b, 0, 1, 0, 1);
      step(idle_b, 0, 1, 0, 1);

      // A,B,C under a 3-cycle stall
      step(mk(1, 10, 0, 0, 32'hA, 0, 0, 0), 1, 0, 0, 1);
      step(mk(1, 11, 0, 0, 32'hB, 0, 0, 0), 1, 0, 0, 1);
      bx = mk(1, 12, 0, 0, 32'hC, 0, 0, 0);
      step(bx, 1, 0, 0, 1);
      chk("ready_low_in_two", 64'(o_MEM_ready), 64'd0);
      step(bx, 1, 1, 0, 1);
      step(bx, 1, 1, 0, 1);
      step(idle_b, 0, 1, 0, 1);
      step(idle_b, 0, 1, 0, 1);
      chk("abc_drained", 64'(sb.size()), 64'd0);

      // Flush while TWO, with a same-cycle beat offered
      step(mk(1, 13, 0, 0, 32'h13, 0, 0, 0), 1, 0, 0, 1);
      step(mk(1, 14, 0, 0, 32'h14, 0, 0, 0), 1, 0, 0, 1);
      step(mk(1, 15, 0, 0, 32'h15, 0, 0, 0), 1, 0, 1, 1);
      step(idle_b, 0, 1, 0, 1);
      chk("flush_valid", 64'(o_WB_valid), 64'd0);
      chk("flush_ready", 64'(o_MEM_ready), 64'd1);
      step(mk(1, 16, 0, 0, 32'h16, 0, 0, 0), 1, 1, 0, 1);
      step(idle_b, 0, 1, 0, 1);
      chk("after_flush_valid", 64'(o_WB_valid), 64'd1);
      step(idle_b, 0, 1, 0, 1);
      chk("after_flush_empty", {63'd0, o_WB_valid}, 64'd0);

      // Reset mid-stream with a held, stalled beat
      step(mk(1, 17, 3, 0, 0, 0, 0, 32'h17), 1, 0, 0, 1);
      step(idle_b, 0, 0, 0, 0);
      chk("ready_mid_reset", 64'(o_MEM_ready), 64'd0);
      step(idle_b, 0, 1, 0, 1);
      chk("mid_reset_outputs", {27'd0, o_WB_valid, o_WB_reg_wr_en, o_WB_rd, o_WB_rd_data}, 64'd0);
      chk("ready_after_mid_reset", 64'(o_MEM_ready), 64'd1);
      step(idle_b, 0, 1, 0, 1);

      // Randomized traffic with random back-pressure and rare flushes
      for (int i = 0; i < 400; i++) begin
         step(rand_beat(), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 39) == 0), 1'b1);
      end

      // Bounded drain
      for (int i = 0; i < 20 && (sb.size() != 0 || o_WB_valid); i++) step(idle_b, 0, 1, 0, 1);
      chk("final_drain", 64'(sb.size()), 64'd0);
      chk("final_idle", 64'(o_WB_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
